// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one combinational ALU between two valid/ready ports, each with a buffered result slot.
// Optional exception hold per port: define ALU_ARB_EXC_HOLD_EN (adds exc0_clear/exc1_clear inputs).
module alu_share_arbiter #(
  parameter int WIDTH     = 32,
  parameter int EXC_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req0_valid,
  output logic                 req0_ready,
  input  logic [WIDTH-1:0]     req0_x,
  input  logic [WIDTH-1:0]     req0_y,
  input  logic [3:0]           req0_op,
  input  logic                 req1_valid,
  output logic                 req1_ready,
  input  logic [WIDTH-1:0]     req1_x,
  input  logic [WIDTH-1:0]     req1_y,
  input  logic [3:0]           req1_op,
  output logic                 resp0_valid,
  input  logic                 resp0_ready,
  output logic [WIDTH-1:0]     resp0_w,
  output logic                 resp0_z,
  output logic [EXC_WIDTH-1:0] resp0_exc,
  output logic                 resp1_valid,
  input  logic                 resp1_ready,
  output logic [WIDTH-1:0]     resp1_w,
  output logic                 resp1_z,
  output logic [EXC_WIDTH-1:0] resp1_exc,
  output logic [WIDTH-1:0]     alu_x,
  output logic [WIDTH-1:0]     alu_y,
  output logic [3:0]           alu_op,
  input  logic [WIDTH-1:0]     alu_w,
  input  logic                 alu_z,
  input  logic [EXC_WIDTH-1:0] alu_exception_code
`ifdef ALU_ARB_EXC_HOLD_EN
  ,
  input  logic                 exc0_clear,
  input  logic                 exc1_clear
`endif
);

  logic                 slot0_free_s, slot1_free_s;
  logic                 elig0_s, elig1_s;
  logic                 grant0_s, grant1_s;
  logic                 hold0_s, hold1_s;
  logic                 exc_nonzero_s;
  logic                 last_grant_q, last_grant_d;

  logic                 resp0_valid_q, resp0_valid_d;
  logic [WIDTH-1:0]     resp0_w_q, resp0_w_d;
  logic                 resp0_z_q, resp0_z_d;
  logic [EXC_WIDTH-1:0] resp0_exc_q, resp0_exc_d;

  logic                 resp1_valid_q, resp1_valid_d;
  logic [WIDTH-1:0]     resp1_w_q, resp1_w_d;
  logic                 resp1_z_q, resp1_z_d;
  logic [EXC_WIDTH-1:0] resp1_exc_q, resp1_exc_d;

  // A slot draining this cycle counts as free, so a port can complete every cycle.
  assign slot0_free_s  = !resp0_valid_q || resp0_ready;
  assign slot1_free_s  = !resp1_valid_q || resp1_ready;
  assign elig0_s       = req0_valid && slot0_free_s && !hold0_s && !reset;
  assign elig1_s       = req1_valid && slot1_free_s && !hold1_s && !reset;
  assign exc_nonzero_s = (alu_exception_code != {EXC_WIDTH{1'b0}});

  // Round-robin grant: on contention the port that did not win last time goes first.
  always_comb begin
    grant0_s = 1'b0;
    grant1_s = 1'b0;
    if (elig0_s && elig1_s) begin
      if (last_grant_q) begin
        grant0_s = 1'b1;
      end else begin
        grant1_s = 1'b1;
      end
    end else if (elig0_s) begin
      grant0_s = 1'b1;
    end else if (elig1_s) begin
      grant1_s = 1'b1;
    end else begin
      grant0_s = 1'b0;
      grant1_s = 1'b0;
    end
  end

  assign req0_ready = grant0_s;
  assign req1_ready = grant1_s;

  // Operand mux: port 0 drives the ALU unless port 1 holds the grant.
  always_comb begin
    alu_x  = req0_x;
    alu_y  = req0_y;
    alu_op = req0_op;
    if (grant1_s) begin
      alu_x  = req1_x;
      alu_y  = req1_y;
      alu_op = req1_op;
    end else begin
      alu_x  = req0_x;
      alu_y  = req0_y;
      alu_op = req0_op;
    end
  end

  // Last-grant pointer update.
  always_comb begin
    last_grant_d = last_grant_q;
    if (grant0_s) begin
      last_grant_d = 1'b0;
    end else if (grant1_s) begin
      last_grant_d = 1'b1;
    end else begin
      last_grant_d = last_grant_q;
    end
  end

  // Port 0 result slot: capture on grant, otherwise clear valid on drain; data is kept.
  always_comb begin
    resp0_valid_d = resp0_valid_q;
    resp0_w_d     = resp0_w_q;
    resp0_z_d     = resp0_z_q;
    resp0_exc_d   = resp0_exc_q;
    if (grant0_s) begin
      resp0_valid_d = 1'b1;
      resp0_w_d     = alu_w;
      resp0_z_d     = alu_z;
      resp0_exc_d   = alu_exception_code;
    end else if (resp0_ready) begin
      resp0_valid_d = 1'b0;
    end else begin
      resp0_valid_d = resp0_valid_q;
    end
  end

  // Port 1 result slot.
  always_comb begin
    resp1_valid_d = resp1_valid_q;
    resp1_w_d     = resp1_w_q;
    resp1_z_d     = resp1_z_q;
    resp1_exc_d   = resp1_exc_q;
    if (grant1_s) begin
      resp1_valid_d = 1'b1;
      resp1_w_d     = alu_w;
      resp1_z_d     = alu_z;
      resp1_exc_d   = alu_exception_code;
    end else if (resp1_ready) begin
      resp1_valid_d = 1'b0;
    end else begin
      resp1_valid_d = resp1_valid_q;
    end
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant_q  <= 1'b1;
      resp0_valid_q <= 1'b0;
      resp0_w_q     <= {WIDTH{1'b0}};
      resp0_z_q     <= 1'b0;
      resp0_exc_q   <= {EXC_WIDTH{1'b0}};
      resp1_valid_q <= 1'b0;
      resp1_w_q     <= {WIDTH{1'b0}};
      resp1_z_q     <= 1'b0;
      resp1_exc_q   <= {EXC_WIDTH{1'b0}};
    end else begin
      last_grant_q  <= last_grant_d;
      resp0_valid_q <= resp0_valid_d;
      resp0_w_q     <= resp0_w_d;
      resp0_z_q     <= resp0_z_d;
      resp0_exc_q   <= resp0_exc_d;
      resp1_valid_q <= resp1_valid_d;
      resp1_w_q     <= resp1_w_d;
      resp1_z_q     <= resp1_z_d;
      resp1_exc_q   <= resp1_exc_d;
    end
  end

`ifdef ALU_ARB_EXC_HOLD_EN
  logic hold0_q, hold0_d;
  logic hold1_q, hold1_d;

  // A capture with a nonzero exception sets the hold; it beats a same-cycle clear.
  always_comb begin
    hold0_d = hold0_q;
    hold1_d = hold1_q;
    if (grant0_s && exc_nonzero_s) begin
      hold0_d = 1'b1;
    end else if (exc0_clear) begin
      hold0_d = 1'b0;
    end else begin
      hold0_d = hold0_q;
    end
    if (grant1_s && exc_nonzero_s) begin
      hold1_d = 1'b1;
    end else if (exc1_clear) begin
      hold1_d = 1'b0;
    end else begin
      hold1_d = hold1_q;
    end
  end

  // Hold registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      hold0_q <= 1'b0;
      hold1_q <= 1'b0;
    end else begin
      hold0_q <= hold0_d;
      hold1_q <= hold1_d;
    end
  end

  assign hold0_s = hold0_q;
  assign hold1_s = hold1_q;
`else
  logic unused_exc_s;
  assign unused_exc_s = exc_nonzero_s;
  assign hold0_s      = 1'b0;
  assign hold1_s      = 1'b0;
`endif

  assign resp0_valid = resp0_valid_q;
  assign resp0_w     = resp0_w_q;
  assign resp0_z     = resp0_z_q;
  assign resp0_exc   = resp0_exc_q;
  assign resp1_valid = resp1_valid_q;
  assign resp1_w     = resp1_w_q;
  assign resp1_z     = resp1_z_q;
  assign resp1_exc   = resp1_exc_q;

endmodule
